// File: rtl/wb_trace.sv
// wb_trace: write-back trace buffer.
// Sits on the register write-back port (we/rwd) and records every committed
// write into a circular FIFO while the capture FSM is in CAPT. The FIFO head is
// drained through a valid/ready port. Writes arriving while the FIFO is full
// and nothing is popped are dropped and counted in a saturating counter.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        synchronous reset, active low
//   we, rwd    register write-back commit strobe and data
//   arm/stop   start / end capture
//   clr        flush FIFO and overflow counter (state untouched)
//   out_valid  FIFO head valid
//   out_data   FIFO head data, read combinationally from storage
//   out_ready  consumer accepts head
//   count      entries held, 0..DEPTH
//   ovf        dropped writes, saturating
//   state      00 IDLE, 01 CAPT, 10 DONE
module wb_trace #(
  parameter int DW           = 16,
  parameter int DEPTH        = 16,
  parameter int AW           = 4,
  parameter int CW           = 8,
  parameter bit STOP_ON_FULL = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [DW-1:0] rwd,
  input  logic          arm,
  input  logic          stop,
  input  logic          clr,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [AW:0]   count,
  output logic [CW-1:0] ovf,
  output logic [1:0]    state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CAPT = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  state_e            st_q, st_d;
  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       cnt_q, cnt_d;
  logic [CW-1:0]     ovf_q;

  logic push_req, push, pop, full, drop, enter_capt;

  assign full      = (cnt_q == FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign out_data  = mem[rd_ptr];
  assign count     = cnt_q;
  assign ovf       = ovf_q;
  assign state     = st_q;

  assign push_req = (st_q == CAPT) && we;
  assign pop      = out_valid && out_ready;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Next-state logic; the register itself holds the state on clr.
  always_comb begin
    st_d       = st_q;
    enter_capt = 1'b0;
    case (st_q)
      IDLE: if (arm) begin
        st_d       = CAPT;
        enter_capt = 1'b1;
      end
      CAPT: begin
        if (stop)
          st_d = DONE;
        else if (STOP_ON_FULL && push && (cnt_d == FULL_CNT))
          st_d = DONE;
      end
      DONE: if (arm) begin
        st_d       = CAPT;
        enter_capt = 1'b1;
      end
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q <= IDLE;
    end else if (!clr) begin
      st_q <= st_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      ovf_q  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt_q <= cnt_d;
      // Entering CAPT cannot coincide with a drop (drops need CAPT already).
      if (enter_capt)
        ovf_q <= '0;
      else if (drop && (ovf_q != '1))
        ovf_q <= ovf_q + 1'b1;
    end
  end

  // Storage has no reset; only entries below count are ever presented.
  always_ff @(posedge clk) begin
    if (rst && !clr && push)
      mem[wr_ptr] <= rwd;
  end

endmodule

// File: tb/tb_wb_trace.sv
module tb_wb_trace;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst, we, arm, stop, clr, out_ready;
  logic [DW-1:0] rwd;

  logic          v0, v1;
  logic [DW-1:0] d0, d1;
  logic [AW:0]   c0, c1;
  logic [CW-1:0] o0, o1;
  logic [1:0]    s0, s1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  wb_trace #(.DW(DW), .DEPTH(16), .AW(AW), .CW(CW), .STOP_ON_FULL(1'b0)) dut (
    .clk(clk), .rst(rst), .we(we), .rwd(rwd), .arm(arm), .stop(stop), .clr(clr),
    .out_valid(v0), .out_data(d0), .out_ready(out_ready),
    .count(c0), .ovf(o0), .state(s0)
  );

  wb_trace #(.DW(DW), .DEPTH(16), .AW(AW), .CW(CW), .STOP_ON_FULL(1'b1)) dut_sof (
    .clk(clk), .rst(rst), .we(we), .rwd(rwd), .arm(arm), .stop(stop), .clr(clr),
    .out_valid(v1), .out_data(d1), .out_ready(out_ready),
    .count(c1), .ovf(o1), .state(s1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b0; we = 1'b0; arm = 1'b0; stop = 1'b0; clr = 1'b0;
    out_ready = 1'b0; rwd = '0;
    tick(); tick();
    chk("rst_state", 32'(s0), 0);
    chk("rst_count", 32'(c0), 0);
    chk("rst_ovf",   32'(o0), 0);
    chk("rst_valid", 32'(v0), 0);
    rst = 1'b1;

    // 1: reset in the middle of a capture
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t1_capt", 32'(s0), 1);
    we = 1'b1;
    rwd = 16'h0001; tick();
    rwd = 16'h0002; tick();
    rwd = 16'h0003; tick();
    we = 1'b0;
    chk("t1_cnt3", 32'(c0), 3);
    rst = 1'b0; tick(); rst = 1'b1;
    chk("t1_state", 32'(s0), 0);
    chk("t1_count", 32'(c0), 0);
    chk("t1_ovf",   32'(o0), 0);
    chk("t1_valid", 32'(v0), 0);

    // 2: basic capture and drain
    arm = 1'b1; tick(); arm = 1'b0;
    we = 1'b1;
    rwd = 16'h0011; tick();
    chk("t2_lat_valid", 32'(v0), 1);
    chk("t2_lat_data",  32'(d0), 32'h11);
    rwd = 16'h0022; tick();
    rwd = 16'h0033; tick();
    we = 1'b0;
    chk("t2_count", 32'(c0), 3);
    out_ready = 1'b1;
    chk("t2_d0", 32'(d0), 32'h11); tick();
    chk("t2_d1", 32'(d0), 32'h22); tick();
    chk("t2_d2", 32'(d0), 32'h33); tick();
    chk("t2_empty", 32'(v0), 0);
    chk("t2_cnt0",  32'(c0), 0);
    tick();
    chk("t2_empty_rdy", 32'(c0), 0);
    out_ready = 1'b0;

    // 3: overflow with drops
    we = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rwd = 16'(16'h0100 + i); tick();
    end
    we = 1'b0;
    chk("t3_count", 32'(c0), 16);
    chk("t3_ovf",   32'(o0), 4);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t3_drain%0d", i), 32'(d0), 32'h100 + i);
      tick();
    end
    out_ready = 1'b0;
    chk("t3_empty", 32'(v0), 0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("t3_done", 32'(s0), 2);
    chk("t3_ovf_kept", 32'(o0), 4);
    we = 1'b1; rwd = 16'hdead; tick(); we = 1'b0;
    chk("t3_done_ignores_we", 32'(c0), 0);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t3_rearm_state", 32'(s0), 1);
    chk("t3_rearm_ovf",   32'(o0), 0);

    // 4: full FIFO with simultaneous push and pop, across pointer wrap
    we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rwd = 16'(16'h0200 + i); tick();
    end
    chk("t4_full", 32'(c0), 16);
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      rwd = 16'(16'h0210 + k);
      chk($sformatf("t4_pp%0d", k), 32'(d0), 32'h200 + k);
      tick();
    end
    we = 1'b0;
    chk("t4_count", 32'(c0), 16);
    chk("t4_ovf",   32'(o0), 0);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t4_drain%0d", i), 32'(d0), 32'h205 + i);
      tick();
    end
    out_ready = 1'b0;
    chk("t4_empty", 32'(v0), 0);

    // 5: STOP_ON_FULL instance
    rst = 1'b0; tick(); rst = 1'b1;
    arm = 1'b1; tick(); arm = 1'b0;
    we = 1'b1;
    for (int i = 0; i < 15; i++) begin
      rwd = 16'(16'h0300 + i); tick();
    end
    chk("t5_capt15", 32'(s1), 1);
    chk("t5_cnt15",  32'(c1), 15);
    rwd = 16'h030f; tick();
    chk("t5_done16", 32'(s1), 2);
    chk("t5_cnt16",  32'(c1), 16);
    rwd = 16'h0310; tick();
    we = 1'b0;
    chk("t5_17_cnt", 32'(c1), 16);
    chk("t5_17_ovf", 32'(o1), 0);
    chk("t5_ref_ovf", 32'(o0), 1);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t5_drain%0d", i), 32'(d1), 32'h300 + i);
      tick();
    end
    out_ready = 1'b0;
    chk("t5_drained", 32'(c1), 0);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t5_rearm", 32'(s1), 1);
    we = 1'b1; rwd = 16'h03aa; tick(); we = 1'b0;
    chk("t5_resume_cnt",  32'(c1), 1);
    chk("t5_resume_data", 32'(d1), 32'h3aa);

    // 6: controls (default instance, currently CAPT, count 1)
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t6_clr_cnt",   32'(c0), 0);
    chk("t6_clr_ovf",   32'(o0), 0);
    chk("t6_clr_state", 32'(s0), 1);
    we = 1'b1; stop = 1'b1; rwd = 16'h0444; tick();
    we = 1'b0; stop = 1'b0;
    chk("t6_stop_state", 32'(s0), 2);
    chk("t6_stop_cnt",   32'(c0), 1);
    chk("t6_stop_data",  32'(d0), 32'h444);
    arm = 1'b1; tick(); arm = 1'b0;
    chk("t6_rearm", 32'(s0), 1);
    arm = 1'b1; stop = 1'b1; tick(); arm = 1'b0; stop = 1'b0;
    chk("t6_armstop", 32'(s0), 2);
    arm = 1'b1; tick(); arm = 1'b0;
    clr = 1'b1; tick(); clr = 1'b0;
    we = 1'b1;
    for (int i = 0; i < 18; i++) begin
      rwd = 16'(16'h0500 + i); tick();
    end
    we = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) tick();
    out_ready = 1'b0;
    chk("t6_pre_cnt",  32'(c0), 5);
    chk("t6_pre_ovf",  32'(o0), 2);
    chk("t6_pre_head", 32'(d0), 32'h50b);
    clr = 1'b1; we = 1'b1; out_ready = 1'b1; rwd = 16'h0fff; tick();
    clr = 1'b0; we = 1'b0; out_ready = 1'b0;
    chk("t6_clr5_cnt",   32'(c0), 0);
    chk("t6_clr5_ovf",   32'(o0), 0);
    chk("t6_clr5_state", 32'(s0), 1);
    chk("t6_clr5_valid", 32'(v0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
